// File: rtl/cv_pkg.sv
// Shared computer-vision constants and helpers for sliding-window blocks.
package cv_pkg;

    // Kernel edge length and number of elements in one kernel window.
    localparam int KERNEL_DIM = 3;
    localparam int WIN_ELEMS  = KERNEL_DIM * KERNEL_DIM;

    // Flat element index of window row i, column j (row 0 = oldest line).
    function automatic int win_idx(input int i, input int j);
        return KERNEL_DIM * i + j;
    endfunction

endpackage

// File: rtl/delaybuffer.sv
// Enable-driven delay line: data_o is the sample accepted delay_p enables ago.
// Implemented as a circular buffer; contents are not reset, only the pointer.
module delaybuffer #(
    parameter int width_p = 8,
    parameter int delay_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               valid_i,
    output logic [width_p-1:0] data_o
);

    localparam int AW = (delay_p > 1) ? $clog2(delay_p) : 1;

    logic [width_p-1:0] mem_q [delay_p];
    logic [AW-1:0]      ptr_q, ptr_d;

    // Read-before-write: the slot about to be overwritten holds the oldest sample.
    assign data_o = mem_q[ptr_q];

    // Wrap the pointer at the programmed depth (need not be a power of two).
    always_comb begin
        ptr_d = (ptr_q == AW'(delay_p - 1)) ? '0 : ptr_q + 1'b1;
    end

    // Pointer advances once per accepted sample.
    always_ff @(posedge clk_i) begin
        if (reset_i)      ptr_q <= '0;
        else if (valid_i) ptr_q <= ptr_d;
    end

    // Storage write; no reset so it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (valid_i) mem_q[ptr_q] <= data_i;
    end

endmodule

// File: rtl/window_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers supply the pixels one and two lines above; three 3-deep
// shift registers hold the neighbourhood; a registered output stage with
// valid/ready handshake presents one window per interior pixel.
module window_3x3
    import cv_pkg::*;
#(
    parameter int width_p        = 8,
    parameter int line_width_p   = 640,
    parameter int frame_height_p = 480
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic [width_p-1:0]             data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic                           valid_o,
    output logic [WIN_ELEMS*width_p-1:0]   window_o,
    output logic                           last_o,
    input  logic                           ready_i
);

    localparam int CW = (line_width_p > 1)   ? $clog2(line_width_p)   : 1;
    localparam int RW = (frame_height_p > 1) ? $clog2(frame_height_p) : 1;

    logic [width_p-1:0] lb0_out, lb1_out;
    logic [KERNEL_DIM-1:0][width_p-1:0] col_in;
    logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][width_p-1:0] sr_q, sr_d;
    logic [WIN_ELEMS*width_p-1:0] win_q, win_d;
    logic [CW-1:0] c_q, c_d;
    logic [RW-1:0] r_q, r_d;
    logic          valid_q, valid_d, last_q, last_d;
    logic          pix_acc, win_acc, emit, at_eol, at_eof;

    // Upstream may push whenever the output slot is empty or being drained.
    assign ready_o = reset_ni && (!valid_q || ready_i);
    assign pix_acc = valid_i && ready_o;
    assign win_acc = valid_q && ready_i;

    assign at_eol = (c_q == CW'(line_width_p - 1));
    assign at_eof = at_eol && (r_q == RW'(frame_height_p - 1));
    // Border pixels (first two rows/columns) complete no window.
    assign emit   = pix_acc && (r_q >= RW'(KERNEL_DIM - 1)) && (c_q >= CW'(KERNEL_DIM - 1));

    // Outputs read as zero while reset is held, not just after the first edge.
    assign valid_o  = valid_q && reset_ni;
    assign last_o   = last_q && reset_ni;
    assign window_o = reset_ni ? win_q : '0;

    // Line buffers: lb0 yields pixel (r-1,c), lb1 yields pixel (r-2,c).
    delaybuffer #(.width_p(width_p), .delay_p(line_width_p)) u_lb0 (
        .clk_i  (clk_i),
        .reset_i(!reset_ni),
        .data_i (data_i),
        .valid_i(pix_acc),
        .data_o (lb0_out)
    );

    delaybuffer #(.width_p(width_p), .delay_p(line_width_p)) u_lb1 (
        .clk_i  (clk_i),
        .reset_i(!reset_ni),
        .data_i (lb0_out),
        .valid_i(pix_acc),
        .data_o (lb1_out)
    );

    assign col_in[0] = lb1_out;
    assign col_in[1] = lb0_out;
    assign col_in[2] = data_i;

    // Raster position of the next pixel to be accepted.
    always_comb begin
        c_d = c_q;
        r_d = r_q;
        if (pix_acc) begin
            if (at_eol) begin
                c_d = '0;
                r_d = (r_q == RW'(frame_height_p - 1)) ? '0 : r_q + 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end
        end
    end

    // Shift the neighbourhood left by one column and pack the resulting window.
    always_comb begin
        sr_d  = sr_q;
        win_d = '0;
        if (pix_acc) begin
            for (int i = 0; i < KERNEL_DIM; i++) begin
                for (int j = 0; j < KERNEL_DIM - 1; j++) sr_d[i][j] = sr_q[i][j+1];
                sr_d[i][KERNEL_DIM-1] = col_in[i];
            end
        end
        for (int i = 0; i < KERNEL_DIM; i++)
            for (int j = 0; j < KERNEL_DIM; j++)
                win_d[win_idx(i, j)*width_p +: width_p] = sr_d[i][j];
    end

    // Output slot: load on a window-producing pixel, else empty on handshake.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        if (emit) begin
            valid_d = 1'b1;
            last_d  = at_eof;
        end else if (win_acc) begin
            valid_d = 1'b0;
        end
    end

    // All state: counters, neighbourhood shift registers and output register.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            c_q     <= '0;
            r_q     <= '0;
            sr_q    <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            c_q     <= c_d;
            r_q     <= r_d;
            sr_q    <= sr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            if (emit) win_q <= win_d;
        end
    end

endmodule

// File: tb/tb_window_3x3.sv
// Scoreboard bench for window_3x3 on a 4x4 frame, pixel = 16*r + c (+offset).
module tb_window_3x3;

    localparam int WD = 8;
    localparam int LW = 4;
    localparam int FH = 4;
    localparam int WB = 9 * WD;

    localparam logic [WB-1:0] FIRST_WIN  = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [WB-1:0] LAST_WIN   = 72'h33_32_31_23_22_21_13_12_11;
    localparam logic [WB-1:0] F2_FIRST   = 72'hA2_A1_A0_92_91_90_82_81_80;

    logic          clk = 1'b0;
    logic          reset_ni = 1'b0;
    logic [WD-1:0] data_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b1;
    logic          ready_o, valid_o, last_o;
    logic [WB-1:0] window_o;

    window_3x3 #(.width_p(WD), .line_width_p(LW), .frame_height_p(FH)) dut (
        .clk_i   (clk),
        .reset_ni(reset_ni),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .window_o(window_o),
        .last_o  (last_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [WB:0]   exp_q[$];
    logic [WB-1:0] got_q[$];
    int            nlast = 0;
    int            rmode = 0;
    int            stall_left = 0;
    bit            stall_armed = 1'b0;
    logic          stalled_prev = 1'b0;
    logic [WB-1:0] win_prev = '0;
    logic [WB:0]   e;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [WB-1:0] model(input int r, input int c, input int off);
        logic [WB-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*WD +: WD] = WD'(16*(r-2+i) + (c-2+j) + off);
        return w;
    endfunction

    // Consumer: always ready, random, or a one-shot 5-cycle stall on the next window.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: ready_i = 1'b1;
            1: ready_i = 1'($urandom_range(0, 1));
            default: begin
                if (stall_armed && valid_o) begin
                    stall_left  = 5;
                    stall_armed = 1'b0;
                end
                if (stall_left > 0) begin
                    ready_i = 1'b0;
                    stall_left--;
                end else begin
                    ready_i = 1'b1;
                end
            end
        endcase
    end

    // Monitor: hold checks during back-pressure, scoreboard compare on handshake.
    always @(negedge clk) begin
        if (stalled_prev) begin
            chk("stall_hold_window", window_o, win_prev);
            chk("stall_hold_valid", valid_o, 1'b1);
        end
        if (valid_o && !ready_i) chk("stall_ready_o", ready_o, 1'b0);
        stalled_prev = reset_ni && valid_o && !ready_i;
        win_prev     = window_o;
        if (reset_ni && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_window: got %0h expected none", window_o);
            end else begin
                e = exp_q.pop_front();
                chk("window", window_o, e[WB-1:0]);
                chk("last", last_o, e[WB]);
            end
            got_q.push_back(window_o);
            if (last_o) nlast++;
        end
    end

    // Offer one pixel and wait (bounded) for it to be accepted.
    task automatic send_pix(input int r, input int c, input int off);
        int n;
        data_i  = WD'(16*r + c + off);
        valid_i = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL pixel_accept_timeout: got no ready_o expected acceptance r=%0d c=%0d", r, c);
                break;
            end
        end
        if (ready_o && r >= 2 && c >= 2)
            exp_q.push_back({(r == FH-1 && c == LW-1), model(r, c, off)});
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic send_frame(input int off, input bit gaps);
        for (int r = 0; r < FH; r++)
            for (int c = 0; c < LW; c++) begin
                send_pix(r, c, off);
                if (gaps) begin
                    int g;
                    g = $urandom_range(0, 2);
                    if (g > 0) begin
                        repeat (g) @(posedge clk);
                        #1;
                    end
                end
            end
    endtask

    task automatic drain();
        int n;
        rmode = 0;
        n = 0;
        while ((exp_q.size() != 0 || valid_o) && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_valid_o", valid_o, 1'b0);
        chk("reset_ready_o", ready_o, 1'b0);
        chk("reset_window_o", window_o, '0);
        chk("reset_last_o", last_o, 1'b0);
        @(posedge clk);
        #1;
        reset_ni = 1'b1;

        // One frame, consumer always ready
        got_q.delete(); nlast = 0;
        send_frame(0, 0);
        drain();
        chk("f1_count", got_q.size(), 4);
        chk("f1_first", got_q[0], FIRST_WIN);
        chk("f1_last", got_q[3], LAST_WIN);
        chk("f1_nlast", nlast, 1);

        // Same frame with a 5-cycle stall on the first window
        got_q.delete(); nlast = 0;
        stall_armed = 1'b1; rmode = 2;
        send_frame(0, 0);
        drain();
        chk("stall_count", got_q.size(), 4);
        chk("stall_first", got_q[0], FIRST_WIN);
        chk("stall_last", got_q[3], LAST_WIN);
        chk("stall_nlast", nlast, 1);

        // Two frames back to back
        got_q.delete(); nlast = 0;
        send_frame(0, 0);
        send_frame(8'h80, 0);
        drain();
        chk("b2b_count", got_q.size(), 8);
        chk("b2b_f2_first", got_q[4], F2_FIRST);
        chk("b2b_nlast", nlast, 2);

        // Reset pulse after pixel 0x21
        got_q.delete(); nlast = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < LW; c++) send_pix(r, c, 0);
        send_pix(2, 0, 0);
        send_pix(2, 1, 0);
        reset_ni = 1'b0;
        @(negedge clk);
        chk("rst_pulse_ready_o", ready_o, 1'b0);
        chk("rst_pulse_valid_o", valid_o, 1'b0);
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        @(negedge clk);
        chk("rst_after_valid_o", valid_o, 1'b0);
        chk("rst_after_window_o", window_o, '0);
        @(posedge clk);
        #1;
        exp_q.delete(); got_q.delete(); nlast = 0;
        send_frame(0, 0);
        drain();
        chk("rst_count", got_q.size(), 4);
        chk("rst_first", got_q[0], FIRST_WIN);
        chk("rst_nlast", nlast, 1);

        // Random input gaps and random back-pressure over two frames
        got_q.delete(); nlast = 0;
        rmode = 1;
        send_frame(0, 1);
        send_frame(8'h80, 1);
        drain();
        chk("rand_count", got_q.size(), 8);
        chk("rand_nlast", nlast, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window_3x3.md
WINDOW_3X3 -- requirements
Module: window_3x3

Interface
REQ-001 SHALL have parameter width_p, default 8, meaning bits per pixel.
REQ-002 SHALL have parameter line_width_p, default 640, meaning pixels per line; legal range >= 3.
REQ-003 SHALL have parameter frame_height_p, default 480, meaning lines per frame; legal range >= 3.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_ni, input, 1 bit: synchronous reset, active low.
REQ-006 SHALL have port data_i, input, width_p bits: raster-order pixel.
REQ-007 SHALL have port valid_i, input, 1 bit: data_i valid.
REQ-008 SHALL have port ready_o, output, 1 bit: block accepts data_i this cycle.
REQ-009 SHALL have port valid_o, output, 1 bit: window_o and last_o valid.
REQ-010 SHALL have port window_o, output, 9*width_p bits: 3x3 neighbourhood.
REQ-011 SHALL have port last_o, output, 1 bit: window is the final one of the frame.
REQ-012 SHALL have port ready_i, input, 1 bit: consumer accepts window_o.

Function
REQ-013 SHALL accept a pixel when valid_i && ready_o, and a window when valid_o && ready_i.
REQ-014 SHALL drive ready_o = reset_ni && (!valid_o || ready_i), sustaining 1 pixel/cycle while ready_i is high.
REQ-015 SHALL track the accepted pixel position (r,c): c counts 0..line_width_p-1, wraps to 0 and increments r; r counts 0..frame_height_p-1 and wraps to 0 at frame end.
REQ-016 SHALL, on acceptance of pixel (r,c) with r>=2 and c>=2, present the window on the next cycle (latency 1), with valid_o=1.
REQ-017 SHALL NOT produce a window for pixels with r<2 or c<2; border pixels are consumed silently, with no padding.
REQ-018 SHALL pack element k=3*i+j, i,j in 0..2, at window_o[k*width_p +: width_p] as pixel (r-2+i, c-2+j); k=8 is the newest pixel.
REQ-019 SHALL assert last_o with the window for pixel (frame_height_p-1, line_width_p-1) only.
REQ-020 SHALL hold window_o, last_o and valid_o stable while valid_o && !ready_i.
REQ-021 SHALL clear valid_o when a window is accepted and no new window is loaded in the same cycle.
REQ-022 SHALL allow a simultaneous window accept and pixel accept; the new window replaces the old without a bubble.
REQ-023 SHALL never let pixels from a previous line's end or a previous frame appear in a window; this is enforced by the r/c gating.
REQ-024 SHALL buffer the two prior lines internally, with line_width_p pixels of storage per line.

Reset
REQ-025 SHALL, while reset_ni=0, drive valid_o=0, last_o=0, window_o=0 and ready_o=0, and clear r, c and the window registers.
REQ-026 SHALL, on reset mid-frame, discard the partial frame; the next accepted pixel is (0,0).
REQ-027 SHALL treat line-buffer contents as don't-care after reset, masked by REQ-017.

Structure
REQ-028 SHALL take the kernel dimension constant (3) and the window element count (9) from the shared computer-vision package, cv_pkg.
REQ-029 SHALL instantiate the existing delaybuffer twice (delay_p = line_width_p) as line buffers, with reset_i driven by !reset_ni.
REQ-030 SHALL keep the counters, 3x3 shift registers and the output register in this module.

Verification (line_width_p=4, frame_height_p=4, pixel value = 16*r+c)
REQ-031 Stream one 4x4 frame with ready_i=1 -> exactly 4 windows; the first, after pixel 0x22, equals k0..k8 = 00,01,02,10,11,12,20,21,22; the last equals 11,12,13,21,22,23,31,32,33 with last_o=1.
REQ-032 Hold ready_i=0 for 5 cycles while a window is pending -> window_o stable, ready_o=0, no pixels lost; the window sequence is identical to REQ-031.
REQ-033 Send two frames back to back -> 8 windows; the first window of frame 2 contains only frame-2 pixels; last_o is seen exactly twice.
REQ-034 Pulse reset_ni=0 for 1 cycle after pixel 0x21 -> valid_o=0; after restart from (0,0) the first window again follows pixel 0x22 and matches REQ-031.
REQ-035 Apply random valid_i gaps and random ready_i -> output matches a reference model window for window, with no duplicates or drops.
